// File: rtl/rps_match_if.sv
// Player handshakes, evaluator link and match status between the controller and its surroundings.
// The master modport is the controller side; slave is the player/evaluator/observer side.
interface rps_match_if;
  logic       match_start;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;
  logic       eval_start;
  logic [1:0] eval_p1_move;
  logic [1:0] eval_p2_move;
  logic [1:0] eval_winner;
  logic [2:0] eval_state;
  logic       round_valid;
  logic [1:0] round_result;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] round_cnt;
  logic       match_done;
  logic [1:0] match_winner;
  logic       busy;

  modport master (
    input  match_start, p1_valid, p1_move, p2_valid, p2_move, eval_winner, eval_state,
    output p1_ready, p2_ready, eval_start, eval_p1_move, eval_p2_move,
           round_valid, round_result, p1_score, p2_score, round_cnt,
           match_done, match_winner, busy
  );

  modport slave (
    output match_start, p1_valid, p1_move, p2_valid, p2_move, eval_winner, eval_state,
    input  p1_ready, p2_ready, eval_start, eval_p1_move, eval_p2_move,
           round_valid, round_result, p1_score, p2_score, round_cnt,
           match_done, match_winner, busy
  );
endinterface

// File: rtl/rps_match_controller.sv
// Best-of-N rock-paper-scissors match sequencer wrapped around a single-round evaluator.
// Collects both moves, runs the evaluator handshake (or forfeits on timeout), scores and ends the match.
module rps_match_controller #(
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter int unsigned MAX_ROUNDS    = 9,
  parameter int unsigned MOVE_TIMEOUT  = 15
) (
  input  logic         clk,
  input  logic         reset,
  rps_match_if.master  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO_W = 8;

  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] WIN_TGT  = CNT_W'(ROUNDS_TO_WIN);
  localparam logic [CNT_W-1:0] ROUND_MX = CNT_W'(MAX_ROUNDS);
  localparam logic [TMO_W:0]   TMO_LIM  = (TMO_W+1)'(MOVE_TIMEOUT);
  localparam logic [2:0]       EV_IDLE  = 3'b000;
  localparam logic [2:0]       EV_EVAL  = 3'b001;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    EVAL_REQ = 3'd2,
    RELEASE  = 3'd3,
    SCORE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             p1_got;
  logic             p2_got;
  logic [1:0]       win_q;

  logic             p1_take_c, p2_take_c, p1_has_c, p2_has_c, tmo_hit_c;
  logic [TMO_W:0]   tmo_inc_c;
  logic [1:0]       verdict_c;
  logic [CNT_W-1:0] p1_next_c, p2_next_c, cnt_next_c;

  // Acceptance, timeout and the scoring applied on SCORE entry (timeout forfeit or evaluator verdict)
  always_comb begin
    p1_take_c  = bus.p1_valid && bus.p1_ready;
    p2_take_c  = bus.p2_valid && bus.p2_ready;
    p1_has_c   = p1_got || p1_take_c;
    p2_has_c   = p2_got || p2_take_c;
    tmo_inc_c  = {1'b0, tmo_cnt} + (TMO_W+1)'(1);
    tmo_hit_c  = tmo_inc_c >= TMO_LIM;
    verdict_c  = (state == COLLECT) ? (p1_has_c ? 2'b01 : 2'b10) : win_q;
    p1_next_c  = bus.p1_score;
    p2_next_c  = bus.p2_score;
    cnt_next_c = bus.round_cnt;
    if (verdict_c == 2'b01 && bus.p1_score != CNT_SAT) p1_next_c = bus.p1_score + CNT_W'(1);
    if (verdict_c == 2'b10 && bus.p2_score != CNT_SAT) p2_next_c = bus.p2_score + CNT_W'(1);
    if (verdict_c != 2'b11 && bus.round_cnt != CNT_SAT) cnt_next_c = bus.round_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      p1_got           <= 1'b0;
      p2_got           <= 1'b0;
      win_q            <= '0;
      bus.p1_ready     <= 1'b0;
      bus.p2_ready     <= 1'b0;
      bus.eval_start   <= 1'b0;
      bus.eval_p1_move <= '0;
      bus.eval_p2_move <= '0;
      bus.round_valid  <= 1'b0;
      bus.round_result <= '0;
      bus.p1_score     <= '0;
      bus.p2_score     <= '0;
      bus.round_cnt    <= '0;
      bus.match_done   <= 1'b0;
      bus.match_winner <= '0;
      bus.busy         <= 1'b0;
    end else begin
      bus.round_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.match_start) begin
            state            <= COLLECT;
            tmo_cnt          <= '0;
            p1_got           <= 1'b0;
            p2_got           <= 1'b0;
            bus.p1_ready     <= 1'b1;
            bus.p2_ready     <= 1'b1;
            bus.eval_p1_move <= '0;
            bus.eval_p2_move <= '0;
            bus.round_result <= '0;
            bus.p1_score     <= '0;
            bus.p2_score     <= '0;
            bus.round_cnt    <= '0;
            bus.match_done   <= 1'b0;
            bus.match_winner <= '0;
            bus.busy         <= 1'b1;
          end
        end
        COLLECT: begin
          if (p1_take_c) begin
            bus.eval_p1_move <= bus.p1_move;
            p1_got           <= 1'b1;
            bus.p1_ready     <= 1'b0;
          end
          if (p2_take_c) begin
            bus.eval_p2_move <= bus.p2_move;
            p2_got           <= 1'b1;
            bus.p2_ready     <= 1'b0;
          end
          if (p1_has_c && p2_has_c) begin
            state          <= EVAL_REQ;
            bus.eval_start <= 1'b1;
          end else if (tmo_hit_c) begin
            // A lone submitter wins by forfeit; with no moves at all the round is void
            tmo_cnt <= '0;
            if (p1_has_c || p2_has_c) begin
              state            <= SCORE;
              bus.p1_ready     <= 1'b0;
              bus.p2_ready     <= 1'b0;
              bus.round_valid  <= 1'b1;
              bus.round_result <= verdict_c;
              bus.p1_score     <= p1_next_c;
              bus.p2_score     <= p2_next_c;
              bus.round_cnt    <= cnt_next_c;
            end
          end else begin
            tmo_cnt <= tmo_inc_c[TMO_W-1:0];
          end
        end
        EVAL_REQ: begin
          if (bus.eval_state == EV_EVAL) begin
            win_q          <= bus.eval_winner;
            bus.eval_start <= 1'b0;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          if (bus.eval_state == EV_IDLE) begin
            state            <= SCORE;
            bus.round_valid  <= 1'b1;
            bus.round_result <= verdict_c;
            bus.p1_score     <= p1_next_c;
            bus.p2_score     <= p2_next_c;
            bus.round_cnt    <= cnt_next_c;
          end
        end
        SCORE: begin
          if (bus.p1_score == WIN_TGT || bus.p2_score == WIN_TGT || bus.round_cnt == ROUND_MX) begin
            state            <= DONE;
            bus.match_done   <= 1'b1;
            bus.busy         <= 1'b0;
            bus.match_winner <= (bus.p1_score == WIN_TGT) ? 2'b01 :
                                (bus.p2_score == WIN_TGT) ? 2'b10 : 2'b00;
          end else begin
            state            <= COLLECT;
            tmo_cnt          <= '0;
            p1_got           <= 1'b0;
            p2_got           <= 1'b0;
            bus.eval_p1_move <= '0;
            bus.eval_p2_move <= '0;
            bus.p1_ready     <= 1'b1;
            bus.p2_ready     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller with a behavioural single-round evaluator.
module tb_rps_match_controller;

  localparam int unsigned RTW = 2;
  localparam int unsigned MAXR = 3;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic reset;
  rps_match_if bus();

  rps_match_controller #(.ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MAXR), .MOVE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] res;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   n_rv     = 0;
  logic [3:0] m_s1, m_s2, m_cnt;
  bit   watch_eval = 1'b0;
  bit   eval_seen  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b11 || b == 2'b11) return 2'b11;
    if (a == b) return 2'b00;
    if ((a == 2'b00 && b == 2'b10) || (a == 2'b01 && b == 2'b00) || (a == 2'b10 && b == 2'b01))
      return 2'b01;
    return 2'b10;
  endfunction

  // Behavioural evaluator: IDLE -> EVALUATE (verdict valid) -> RESULT until start drops
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.eval_state  <= 3'b000;
      bus.eval_winner <= 2'b00;
    end else begin
      case (bus.eval_state)
        3'b000: if (bus.eval_start) begin
          bus.eval_state  <= 3'b001;
          bus.eval_winner <= judge(bus.eval_p1_move, bus.eval_p2_move);
        end
        3'b001: bus.eval_state <= 3'b010;
        3'b010: if (!bus.eval_start) bus.eval_state <= 3'b000;
        default: bus.eval_state <= 3'b000;
      endcase
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && watch_eval && bus.eval_start) eval_seen = 1'b1;
    if (!reset && bus.round_valid) begin
      exp_t e;
      n_rv++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_round", 32'(bus.round_result), 32'hFF);
      end else begin
        e = sb_q.pop_front();
        check("round_result", 32'(bus.round_result), 32'(e.res));
        check("p1_score", 32'(bus.p1_score), 32'(e.s1));
        check("p2_score", 32'(bus.p2_score), 32'(e.s2));
        check("round_cnt", 32'(bus.round_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic push_exp(input logic [1:0] v);
    exp_t e;
    if (v == 2'b01) m_s1 = m_s1 + 4'd1;
    if (v == 2'b10) m_s2 = m_s2 + 4'd1;
    if (v != 2'b11) m_cnt = m_cnt + 4'd1;
    e.res = v; e.s1 = m_s1; e.s2 = m_s2; e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic start_match();
    bus.match_start = 1'b1;
    @(negedge clk);
    bus.match_start = 1'b0;
    m_s1 = '0; m_s2 = '0; m_cnt = '0;
    check("start_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_both_ready();
    int i;
    for (i = 0; i < 20; i++) begin
      if (bus.p1_ready && bus.p2_ready) break;
      @(negedge clk);
    end
    if (i == 20) check("ready_timeout", 32'(i), 32'd0);
  endtask

  task automatic wait_round();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.round_valid) break;
    end
    if (i == 40) check("round_timeout", 32'(i), 32'd0);
  endtask

  task automatic play(input logic [1:0] m1, input logic [1:0] m2);
    wait_both_ready();
    push_exp(judge(m1, m2));
    bus.p1_valid = 1'b1; bus.p1_move = m1;
    bus.p2_valid = 1'b1; bus.p2_move = m2;
    @(negedge clk);
    bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
    check("accept_ready_drop", 32'({bus.p1_ready, bus.p2_ready}), 32'd0);
    check("accept_eval_start", 32'(bus.eval_start), 32'd1);
    check("eval_moves", 32'({bus.eval_p1_move, bus.eval_p2_move}), 32'({m1, m2}));
    wait_round();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, rv0;
    reset = 1'b1;
    bus.match_start = 1'b0;
    bus.p1_valid = 1'b0; bus.p1_move = 2'b00;
    bus.p2_valid = 1'b0; bus.p2_move = 2'b00;
    m_s1 = '0; m_s2 = '0; m_cnt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ctrl", 32'({bus.busy, bus.match_done, bus.p1_ready, bus.p2_ready, bus.eval_start, bus.round_valid}), 32'd0);
    check("rst_data", 32'({bus.p1_score, bus.p2_score, bus.round_cnt, bus.round_result, bus.match_winner,
                          bus.eval_p1_move, bus.eval_p2_move}), 32'd0);

    // Best-of-3: stone beats scissors twice, with a match_start pulse mid-match
    start_match();
    play(2'b00, 2'b10);
    @(negedge clk);
    bus.match_start = 1'b1;
    @(negedge clk);
    bus.match_start = 1'b0;
    @(negedge clk);
    check("busy_ignore_start", 32'({bus.busy, bus.match_done, bus.p1_score}), 32'({1'b1, 1'b0, 4'd1}));
    play(2'b00, 2'b10);
    @(negedge clk);
    check("p1_win_done", 32'({bus.match_done, bus.busy, bus.match_winner}), 32'({1'b1, 1'b0, 2'b01}));
    check("p1_win_tally", 32'({bus.p1_score, bus.p2_score, bus.round_cnt}), 32'({4'd2, 4'd0, 4'd2}));

    // Draw by MAX_ROUNDS ties, restarted from DONE
    start_match();
    for (int r = 0; r < int'(MAXR); r++) play(2'b01, 2'b01);
    @(negedge clk);
    check("draw_done", 32'({bus.match_done, bus.match_winner}), 32'({1'b1, 2'b00}));
    check("draw_tally", 32'({bus.p1_score, bus.p2_score, bus.round_cnt}), 32'({4'd0, 4'd0, 4'd3}));

    // Invalid move replays the round
    start_match();
    play(2'b11, 2'b00);
    @(negedge clk);
    check("replay_ready", 32'({bus.p1_ready, bus.p2_ready}), 32'd3);
    check("replay_cnt", 32'(bus.round_cnt), 32'd0);

    // Only P2 submits: forfeit after TMO collect cycles without the evaluator
    push_exp(2'b10);
    watch_eval = 1'b1;
    bus.p2_valid = 1'b1; bus.p2_move = 2'b00;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.p2_valid = 1'b0;
      if (bus.round_valid) break;
    end
    check("timeout_cycles", 32'(k), 32'(TMO));
    watch_eval = 1'b0;
    check("timeout_no_eval", 32'(eval_seen), 32'd0);

    // Nobody submits: void rounds, nothing scored
    @(negedge clk);
    #1 rv0 = n_rv;
    repeat (2 * TMO + 2) @(negedge clk);
    #1;
    check("void_no_round", 32'(n_rv), 32'(rv0));
    check("void_state", 32'({bus.p1_ready, bus.p2_ready, bus.busy, bus.round_cnt}), 32'({3'b111, 4'd1}));

    // Reset while in EVAL_REQ aborts the match immediately
    bus.p1_valid = 1'b1; bus.p1_move = 2'b01;
    bus.p2_valid = 1'b1; bus.p2_move = 2'b00;
    @(negedge clk);
    check("evalreq_start", 32'(bus.eval_start), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_ctrl", 32'({bus.eval_start, bus.busy, bus.p1_ready, bus.p2_ready, bus.match_done}), 32'd0);
    check("abort_data", 32'({bus.p1_score, bus.p2_score, bus.round_cnt, bus.eval_p1_move, bus.eval_p2_move}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_accept", 32'({bus.p1_ready, bus.p2_ready, bus.busy}), 32'd0);
    bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
